eac_adder_arbiter: RTL and testbench

EAC_ADDER_ARBITER -- requirements
Module: eac_adder_arbiter

---
 rtl/eac_adder_arbiter.sv | 164 ++++++++++++++++
 tb/tb_eac_adder_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/eac_adder_arbiter.sv
// Two-requester round-robin front end sharing one carry-lookahead adder, with a
// single-entry registered result slot. Define EAC_ARB_CHECK_EN to enable the sum checker.

module eac_cla_adder #(
    parameter int ADDER_WIDTH = 48
) (
    input  logic [ADDER_WIDTH-1:0] a,
    input  logic [ADDER_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [ADDER_WIDTH-1:0] sum,
    output logic                   cout
);
    localparam int NG = (ADDER_WIDTH + 3) / 4;

    logic [ADDER_WIDTH-1:0] g, p;

    assign g = a & b;
    assign p = a ^ b;

    // 4-bit groups: group carry is resolved from group generate/propagate,
    // bits inside a group see their carry from the group's carry-in.
    always_comb begin
        logic grp_c, bit_c, gg, gp;
        int   idx;
        sum   = '0;
        grp_c = cin;
        bit_c = 1'b0;
        gg    = 1'b0;
        gp    = 1'b1;
        idx   = 0;
        for (int k = 0; k < NG; k++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int j = 0; j < 4; j++) begin
                idx = k * 4 + j;
                if (idx < ADDER_WIDTH) begin
                    gg = g[idx] | (p[idx] & gg);
                    gp = gp & p[idx];
                end
            end
            bit_c = grp_c;
            for (int j = 0; j < 4; j++) begin
                idx = k * 4 + j;
                if (idx < ADDER_WIDTH) begin
                    sum[idx] = p[idx] ^ bit_c;
                    bit_c    = g[idx] | (p[idx] & bit_c);
                end
            end
            grp_c = gg | (gp & grp_c);
        end
        cout = grp_c;
    end
endmodule

module eac_adder_arbiter #(
    parameter int ADDER_WIDTH = 48
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    input  logic                   req1_valid,
    output logic                   req0_ready,
    output logic                   req1_ready,
    input  logic [ADDER_WIDTH-1:0] req0_a,
    input  logic [ADDER_WIDTH-1:0] req0_b,
    input  logic [ADDER_WIDTH-1:0] req1_a,
    input  logic [ADDER_WIDTH-1:0] req1_b,
    input  logic                   req0_cin,
    input  logic                   req1_cin,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ADDER_WIDTH-1:0] res_sum,
    output logic                   res_cout,
    output logic                   res_id,
    output logic                   chk_error
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [ADDER_WIDTH-1:0] sum_q, sum_d;
    logic                   cout_q, cout_d;
    logic                   id_q, id_d;
    logic                   last_q, last_d;

    logic                   accept, gnt0, gnt1, xfer;
    logic [ADDER_WIDTH-1:0] op_a, op_b, add_sum;
    logic                   op_cin, add_cout;

    // last_q holds the id of the last granted requester; the other wins a tie.
    assign accept = (state_q == EMPTY) || res_ready;
    assign gnt0   = req0_valid && (!req1_valid || last_q);
    assign gnt1   = req1_valid && (!req0_valid || !last_q);

    assign req0_ready = !reset && accept && gnt0;
    assign req1_ready = !reset && accept && gnt1;
    assign xfer       = req0_ready || req1_ready;

    assign op_a   = gnt1 ? req1_a   : req0_a;
    assign op_b   = gnt1 ? req1_b   : req0_b;
    assign op_cin = gnt1 ? req1_cin : req0_cin;

    eac_cla_adder #(.ADDER_WIDTH(ADDER_WIDTH)) u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        id_d    = id_q;
        last_d  = last_q;
        if (xfer) begin
            state_d = FULL;
            sum_d   = add_sum;
            cout_d  = add_cout;
            id_d    = gnt1;
            last_d  = gnt1;
        end else if (res_ready) begin
            state_d = EMPTY;
        end
    end

`ifdef EAC_ARB_CHECK_EN
    logic                 chk_q, chk_d;
    logic [ADDER_WIDTH:0] ref_sum;

    assign ref_sum = {1'b0, op_a} + {1'b0, op_b} + {{ADDER_WIDTH{1'b0}}, op_cin};
    assign chk_d   = chk_q || (xfer && (ref_sum != {add_cout, add_sum}));

    always_ff @(posedge clk) begin
        if (reset) chk_q <= 1'b0;
        else       chk_q <= chk_d;
    end

    assign chk_error = chk_q;
`else
    assign chk_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;
endmodule

// File: tb/tb_eac_adder_arbiter.sv
// Scoreboard bench for eac_adder_arbiter: a transaction-level model predicts
// grants and results, a monitor compares every presented result.

module tb_eac_adder_arbiter;
    localparam int W = 48;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_cin = 1'b0, req1_cin = 1'b0;
    logic         res_valid, res_ready = 1'b0;
    logic [W-1:0] res_sum;
    logic         res_cout, res_id, chk_error;

    eac_adder_arbiter #(.ADDER_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_cin(req0_cin), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
        .chk_error(chk_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
    } res_t;

    res_t q[$];
    int   n_pass = 0, n_total = 0;

    // Model state: whether a result is pending, who was granted last, and
    // whether the previous edge was a reset edge.
    bit   full_m = 0;
    int   last_m = 1;
    bit   after_rst = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic cyc(input logic v0, input logic v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1,
                       input logic rr, input logic rst);
        logic e0, e1;
        int   win;
        logic [W:0] full_sum;
        res_t r;
        @(posedge clk);
        #1;
        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_a = a1; req1_b = b1; req1_cin = c1;
        res_ready = rr; reset = rst;
        @(negedge clk);
        if (after_rst) begin
            chk("rst_res_valid", 64'(res_valid), 64'd0);
            chk("rst_res_sum", 64'(res_sum), 64'd0);
            chk("rst_res_cout", 64'(res_cout), 64'd0);
            chk("rst_res_id", 64'(res_id), 64'd0);
            chk("rst_chk_error", 64'(chk_error), 64'd0);
        end
        win = -1;
        if (!rst && (!full_m || rr)) begin
            if (v0 && v1) win = (last_m == 0) ? 1 : 0;
            else if (v0)  win = 0;
            else if (v1)  win = 1;
        end
        e0 = (win == 0);
        e1 = (win == 1);
        chk("req0_ready", 64'(req0_ready), 64'(e0));
        chk("req1_ready", 64'(req1_ready), 64'(e1));
        chk("res_valid", 64'(res_valid), 64'(full_m));
        chk("chk_error", 64'(chk_error), 64'd0);
        after_rst = rst;
        if (rst) begin
            full_m = 0;
            last_m = 1;
            q.delete();
        end else if (win >= 0) begin
            full_sum = (win == 0) ? ({1'b0, a0} + {1'b0, b0} + (W+1)'(c0))
                                  : ({1'b0, a1} + {1'b0, b1} + (W+1)'(c1));
            r.sum  = full_sum[W-1:0];
            r.cout = full_sum[W];
            r.id   = (win == 1);
            q.push_back(r);
            last_m = win;
            full_m = 1;
        end else if (full_m && rr) begin
            full_m = 0;
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: return '1;
            1: return '0;
            default: return v[W-1:0];
        endcase
    endfunction

    // Monitor: compare whatever the DUT presents against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && res_valid) begin
                if (q.size() == 0) begin
                    chk("res_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("res_sum", 64'(res_sum), 64'(q[0].sum));
                    chk("res_cout", 64'(res_cout), 64'(q[0].cout));
                    chk("res_id", 64'(res_id), 64'(q[0].id));
                    if (res_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [W-1:0] z;
        z = '0;
        cyc(0, 0, z, z, 0, z, z, 0, 0, 1);
        cyc(0, 0, z, z, 0, z, z, 0, 0, 1);
        // Single requester cases, including full-width wrap with carry out.
        cyc(1, 0, 48'h00000000FFFF, 48'h000000000001, 0, z, z, 0, 1, 0);
        cyc(0, 0, z, z, 0, z, z, 0, 1, 0);
        cyc(0, 1, z, z, 0, 48'hFFFFFFFFFFFF, 48'h000000000001, 0, 1, 0);
        cyc(0, 0, z, z, 0, z, z, 0, 1, 0);
        // Contention straight after reset: 0,1,0,1 back to back.
        cyc(0, 0, z, z, 0, z, z, 0, 1, 1);
        for (int i = 0; i < 4; i++)
            cyc(1, 1, rnd(), rnd(), 1'(i), rnd(), rnd(), 1'(~i), 1, 0);
        cyc(0, 0, z, z, 0, z, z, 0, 1, 0);
        // Back-pressure: fill, stall three cycles, then drain and refill.
        cyc(1, 1, rnd(), rnd(), 1, rnd(), rnd(), 0, 1, 0);
        for (int i = 0; i < 3; i++)
            cyc(1, 1, rnd(), rnd(), 0, rnd(), rnd(), 1, 0, 0);
        cyc(1, 1, rnd(), rnd(), 1, rnd(), rnd(), 1, 1, 0);
        cyc(0, 0, z, z, 0, z, z, 0, 0, 0);
        // Reset while FULL discards the slot; next contention goes to 0.
        cyc(1, 1, rnd(), rnd(), 0, rnd(), rnd(), 0, 0, 1);
        cyc(1, 1, rnd(), rnd(), 0, rnd(), rnd(), 1, 1, 0);
        cyc(0, 0, z, z, 0, z, z, 0, 1, 0);
        // Carry-chain sweep around a 16-bit boundary.
        for (int i = 0; i < 64; i++)
            cyc(1, 0, 48'hFFFF + 48'(i), 48'd1 + 48'(i), 1'(i), z, z, 0, 1, 0);
        // Random traffic with random back-pressure and occasional reset.
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                rnd(), rnd(), 1'($urandom), rnd(), rnd(), 1'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
        cyc(0, 0, z, z, 0, z, z, 0, 1, 0);
        cyc(0, 0, z, z, 0, z, z, 0, 1, 0);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
